// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides
// and an architectural Z/V/N flag register. Flags are committed in program
// order, at the moment a result is taken by the consumer.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     issue handshake into stage 1
//   opcode, a, b, imm       operation and operands, captured on issue
//   out_valid / out_ready   result handshake out of stage 2
//   result                  stage-2 result register
//   flag_z, flag_v, flag_n  committed flags
//
// Optional feature macro: ALU_SAT_ADD_EN
//   defined   -> ADD/SUB saturate on signed overflow
//   undefined -> ADD/SUB wrap modulo 2^WIDTH

// One PADDSB lane: signed add saturated to the lane's signed range.
module alu_pipe_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum
);
    logic [LANE_W:0] ext;

    always_comb begin
        ext = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        sum = ext[LANE_W-1:0];
        // Top two bits disagree -> result left the lane's signed range.
        if (ext[LANE_W] != ext[LANE_W-1])
            sum = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
endmodule

module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int LANE_W  = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               flag_z,
    output logic               flag_v,
    output logic               flag_n
);
    localparam int NUM_LANES = WIDTH / LANE_W;
    localparam int NUM_BYTES = WIDTH / 8;
    // Sum of 2*NUM_BYTES signed bytes needs 8 + clog2(count) bits, +1 for margin.
    localparam int RED_W = 8 + $clog2(2 * NUM_BYTES) + 1;
    localparam int ACC_W = (RED_W > WIDTH) ? RED_W : WIDTH;

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_RED = 4'd3,
                           OP_SLL = 4'd4, OP_SRA = 4'd5, OP_ROR = 4'd6, OP_PADD = 4'd7;

    // Stage 1 registers
    logic               s1_valid;
    logic [3:0]         s1_op;
    logic [WIDTH-1:0]   s1_a, s1_b;
    logic [SHAMT_W-1:0] s1_imm;

    // Stage 2 pending flag update, applied when the result is handed off
    logic s2_wz, s2_wvn, s2_z, s2_v, s2_n;

    logic adv2;
    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;

    // PADDSB lanes
    logic [NUM_LANES-1:0][LANE_W-1:0] lane_a, lane_b, lane_s;
    assign lane_a = s1_a;
    assign lane_b = s1_b;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            alu_pipe_lane #(.LANE_W(LANE_W)) u_lane (
                .a   (lane_a[gi]),
                .b   (lane_b[gi]),
                .sum (lane_s[gi])
            );
        end
    endgenerate

    // Stage 2 compute
    logic [WIDTH-1:0] add_w, sub_w, ror_w, nxt_res;
    logic             add_ov, sub_ov, nxt_v, nxt_wz, nxt_wvn;
    logic [ACC_W-1:0] red_acc;

    always_comb begin
        add_w  = s1_a + s1_b;
        sub_w  = s1_a - s1_b;
        add_ov = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_w[WIDTH-1] != s1_a[WIDTH-1]);
        sub_ov = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_w[WIDTH-1] != s1_a[WIDTH-1]);

        red_acc = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            red_acc = red_acc + {{(ACC_W-8){s1_a[8*i+7]}}, s1_a[8*i +: 8]}
                              + {{(ACC_W-8){s1_b[8*i+7]}}, s1_b[8*i +: 8]};
        end

        ror_w = '0;
        for (int i = 0; i < WIDTH; i++)
            ror_w[i] = s1_a[(i + int'(s1_imm)) % WIDTH];

        nxt_res = s1_a;
        nxt_v   = 1'b0;
        nxt_wz  = 1'b0;
        nxt_wvn = 1'b0;
        case (s1_op)
            OP_ADD: begin
                nxt_res = add_w;
                nxt_v   = add_ov;
                nxt_wz  = 1'b1;
                nxt_wvn = 1'b1;
`ifdef ALU_SAT_ADD_EN
                // Overflow direction follows the sign of a for both ADD and SUB.
                if (add_ov) nxt_res = s1_a[WIDTH-1] ? S_MIN : S_MAX;
`endif
            end
            OP_SUB: begin
                nxt_res = sub_w;
                nxt_v   = sub_ov;
                nxt_wz  = 1'b1;
                nxt_wvn = 1'b1;
`ifdef ALU_SAT_ADD_EN
                if (sub_ov) nxt_res = s1_a[WIDTH-1] ? S_MIN : S_MAX;
`endif
            end
            OP_XOR:  begin nxt_res = s1_a ^ s1_b;                   nxt_wz = 1'b1; end
            OP_RED:        nxt_res = red_acc[WIDTH-1:0];
            OP_SLL:  begin nxt_res = s1_a << s1_imm;                nxt_wz = 1'b1; end
            OP_SRA:  begin nxt_res = WIDTH'($signed(s1_a) >>> s1_imm); nxt_wz = 1'b1; end
            OP_ROR:  begin nxt_res = ror_w;                         nxt_wz = 1'b1; end
            OP_PADD:       nxt_res = lane_s;
            default:       nxt_res = s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_imm    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            s2_wz     <= 1'b0;
            s2_wvn    <= 1'b0;
            s2_z      <= 1'b0;
            s2_v      <= 1'b0;
            s2_n      <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            // Commit uses the departing op's S2 contents, read before they are
            // overwritten by a same-cycle advance.
            if (out_valid && out_ready) begin
                if (s2_wz) flag_z <= s2_z;
                if (s2_wvn) begin
                    flag_v <= s2_v;
                    flag_n <= s2_n;
                end
            end

            if (adv2) begin
                out_valid <= 1'b1;
                result    <= nxt_res;
                s2_wz     <= nxt_wz;
                s2_wvn    <= nxt_wvn;
                s2_z      <= (nxt_res == '0);
                s2_v      <= nxt_v;
                s2_n      <= nxt_res[WIDTH-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_op    <= opcode;
                s1_a     <= a;
                s1_b     <= b;
                s1_imm   <= imm;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (WIDTH=16, LANE_W=4).
// Expected values are hand-computed; saturating expectations are selected
// by the same ALU_SAT_ADD_EN macro as the design.
module tb_alu_pipe;
`ifdef ALU_SAT_ADD_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [15:0] a = '0, b = '0;
    logic [3:0]  imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        flag_z, flag_v, flag_n;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flg();
        return {flag_z, flag_v, flag_n};
    endfunction

    task automatic present(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                           input logic [3:0] im);
        in_valid = 1'b1;
        opcode   = op;
        a        = av;
        b        = bv;
        imm      = im;
    endtask

    // Issue one op with out_ready=1; check latency, result and committed flags ({z,v,n}).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] av,
                          input logic [15:0] bv, input logic [3:0] im,
                          input logic [15:0] exp_res, input logic [2:0] exp_flg);
        int cyc;
        @(negedge clk);
        chk({tag, ".rdy"}, in_ready, 1);
        present(op, av, bv, im);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, cyc, 2);
        chk({tag, ".res"}, result, exp_res);
        @(negedge clk);
        chk({tag, ".flg"}, flg(), exp_flg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ov", out_valid, 0);
        chk("rst.res", result, 0);
        chk("rst.flg", flg(), 3'b000);
        chk("rst.rdy", in_ready, 1);
        rst_n = 1'b1;

        run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 4'd0,
               SAT ? 16'h7FFF : 16'h8000, SAT ? 3'b010 : 3'b011);
        run_op("padd1", 4'd7, 16'h7654, 16'h1234, 4'd0, 16'h7777, SAT ? 3'b010 : 3'b011);
        run_op("padd2", 4'd7, 16'h8000, 16'hF000, 4'd0, 16'h8000, SAT ? 3'b010 : 3'b011);
        run_op("red",   4'd3, 16'h0102, 16'h03FC, 4'd0, 16'h0002, SAT ? 3'b010 : 3'b011);
        run_op("xor0",  4'd2, 16'h1234, 16'h1234, 4'd0, 16'h0000, SAT ? 3'b110 : 3'b111);
        run_op("sub_ovf", 4'd1, 16'h8000, 16'h0001, 4'd0,
               SAT ? 16'h8000 : 16'h7FFF, SAT ? 3'b011 : 3'b010);
        run_op("sub0",  4'd1, 16'h0005, 16'h0005, 4'd0, 16'h0000, 3'b100);
        run_op("sra",   4'd5, 16'h8000, 16'h0000, 4'd3, 16'hF000, 3'b000);
        run_op("ror1",  4'd6, 16'h0001, 16'h0000, 4'd1, 16'h8000, 3'b000);
        run_op("ror0",  4'd6, 16'h1234, 16'h0000, 4'd0, 16'h1234, 3'b000);
        run_op("ror4",  4'd6, 16'h1234, 16'h0000, 4'd4, 16'h4123, 3'b000);
        run_op("sll1",  4'd4, 16'h8001, 16'h0000, 4'd1, 16'h0002, 3'b000);
        run_op("sll0",  4'd4, 16'h8000, 16'h0000, 4'd1, 16'h0000, 3'b100);
        run_op("pass",  4'd9, 16'hABCD, 16'h1111, 4'd2, 16'hABCD, 3'b100);
        run_op("add",   4'd0, 16'h0003, 16'h0004, 4'd0, 16'h0007, 3'b000);
        run_op("add_wrapz", 4'd0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 3'b100);
        run_op("add_neg", 4'd0, 16'hFFFF, 16'hFFFF, 4'd0, 16'hFFFE, 3'b001);

        // Stall: out_ready low for 6 cycles while issuing 3 ops
        @(negedge clk);
        out_ready = 1'b0;
        present(4'd0, 16'h0001, 16'h0001, 4'd0);          // A: ADD -> 0x0002
        @(negedge clk);
        chk("stall.rdy1", in_ready, 1);
        present(4'd1, 16'h0001, 16'h0002, 4'd0);          // B: SUB -> 0xFFFF
        @(negedge clk);
        chk("stall.rdy2", in_ready, 0);
        present(4'd2, 16'h00FF, 16'h0F0F, 4'd0);          // C: XOR -> 0x0FF0
        repeat (3) @(negedge clk);
        chk("stall.rdy_hold", in_ready, 0);
        chk("stall.ov", out_valid, 1);
        chk("stall.res", result, 16'h0002);
        chk("stall.flg", flg(), 3'b001);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rel.resB", result, 16'hFFFF);
        chk("rel.flgA", flg(), 3'b000);
        @(negedge clk);
        chk("rel.resC", result, 16'h0FF0);
        chk("rel.ovC", out_valid, 1);
        chk("rel.flgB", flg(), 3'b001);
        @(negedge clk);
        chk("rel.ov_end", out_valid, 0);
        chk("rel.flgC", flg(), 3'b001);

        // Async reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        present(4'd0, 16'h4000, 16'h4000, 4'd0);
        @(negedge clk);
        present(4'd0, 16'h0001, 16'h0001, 4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full.ov", out_valid, 1);
        chk("full.rdy", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.ov", out_valid, 0);
        chk("arst.flg", flg(), 3'b000);
        chk("arst.res", result, 0);
        chk("arst.rdy", in_ready, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_op("post_rst", 4'd0, 16'h0002, 16'h0003, 4'd0, 16'h0005, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
